// File: rtl/sys_ctrl_pkg.sv
// Shared types and constants for the systolic tile scheduler and its skew stage.
package sys_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FEED   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4,
        ST_WAIT   = 3'd5,
        ST_RESULT = 3'd6
    } state_t;

    localparam int DEF_ARR_HEIGHT = 4;
    localparam int DEF_ARR_WIDTH  = 4;

    function automatic int skew_depth(input int h, input int w);
        return (h > w) ? h : w;
    endfunction

    localparam int SKEW_DEPTH  = skew_depth(DEF_ARR_HEIGHT, DEF_ARR_WIDTH);
    localparam int SA_DONE_LAT = DEF_ARR_HEIGHT + DEF_ARR_WIDTH + 4;

endpackage

// File: rtl/systolic_tile_scheduler_skew.sv
// Triangular delay array: lane i of din appears on dout after 1 + i cycles.
module skew_buffer
    import sys_ctrl_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [LANES*WIDTH-1:0] din,
    output logic [LANES*WIDTH-1:0] dout
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] taps [i+1];

        // Zeros enter whenever no beat is loaded, so idle cycles add nothing downstream.
        always_ff @(posedge clk) begin
            if (!reset) begin
                for (int d = 0; d <= i; d++) taps[d] <= '0;
            end else begin
                taps[0] <= load ? din[i*WIDTH +: WIDTH] : '0;
                for (int d = 1; d <= i; d++) taps[d] <= taps[d-1];
            end
        end

        assign dout[i*WIDTH +: WIDTH] = taps[i];
    end

endmodule

// File: rtl/systolic_tile_scheduler.sv
// Sequences one tile through a systolic array: clear, skewed operand feed, flush,
// done pulse, bounded wait for completion, then a held valid/ready result.
module systolic_tile_scheduler
    import sys_ctrl_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4,
    parameter int K_BITS     = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic [K_BITS-1:0]                   cmd_k,
    input  logic                                op_valid,
    output logic                                op_ready,
    input  logic [ARR_HEIGHT*WIDTH-1:0]         op_a,
    input  logic [ARR_WIDTH*WIDTH-1:0]          op_b,
    output logic                                sa_reset,
    output logic [ARR_HEIGHT*WIDTH-1:0]         sa_in_a,
    output logic [ARR_WIDTH*WIDTH-1:0]          sa_in_b,
    output logic                                sa_done,
    input  logic                                sa_calc_done,
    input  logic [ARR_HEIGHT*ARR_WIDTH*WIDTH-1:0] sa_out_c,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [ARR_HEIGHT*ARR_WIDTH*WIDTH-1:0] res_data,
    output logic                                err_timeout
);

    localparam int FLUSH_CYCLES = skew_depth(ARR_HEIGHT, ARR_WIDTH) - 1;
    localparam int FLUSH_W      = $clog2(FLUSH_CYCLES + 2);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST =
        FLUSH_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t              state;
    state_t              state_next;
    logic [K_BITS-1:0]   k_reg;
    logic [K_BITS-1:0]   beat_cnt;
    logic [FLUSH_W-1:0]  flush_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                beat_fire;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // cmd_ready, op_ready and res_valid are decoded from the state only.
    assign beat_fire = (state == ST_FEED) && op_valid;

    // The array reset follows the block reset directly so a mid-tile reset clears it at once.
    assign sa_reset = reset && (state != ST_CLEAR);

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        op_ready   = 1'b0;
        sa_done    = 1'b0;
        res_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = ST_CLEAR;
            end
            ST_CLEAR: state_next = (k_reg == '0) ? ST_FLUSH : ST_FEED;
            ST_FEED: begin
                op_ready = 1'b1;
                if (beat_fire && (beat_cnt == k_reg - K_BITS'(1))) state_next = ST_FLUSH;
            end
            ST_FLUSH: if (flush_cnt == FLUSH_LAST) state_next = ST_DONE;
            ST_DONE: begin
                sa_done    = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: if (sa_calc_done || (wait_cnt == WAIT_LAST)) state_next = ST_RESULT;
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            k_reg       <= '0;
            beat_cnt    <= '0;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            res_data    <= '0;
            err_timeout <= 1'b0;
        end else begin
            flush_cnt <= (state == ST_FLUSH) ? flush_cnt + FLUSH_W'(1) : '0;
            wait_cnt  <= (state == ST_WAIT)  ? wait_cnt + WAIT_W'(1)   : '0;
            if ((state == ST_IDLE) && cmd_valid) begin
                k_reg       <= cmd_k;
                beat_cnt    <= '0;
                err_timeout <= 1'b0;
            end
            if (beat_fire) beat_cnt <= beat_cnt + K_BITS'(1);
            // A completion arriving on the last allowed cycle wins over the timeout.
            if (state == ST_WAIT) begin
                if (sa_calc_done) begin
                    res_data <= sa_out_c;
                end else if (wait_cnt == WAIT_LAST) begin
                    res_data    <= '0;
                    err_timeout <= 1'b1;
                end
            end
        end
    end

    skew_buffer #(
        .LANES (ARR_HEIGHT),
        .WIDTH (WIDTH)
    ) u_skew_west (
        .clk   (clk),
        .reset (reset),
        .load  (beat_fire),
        .din   (op_a),
        .dout  (sa_in_a)
    );

    skew_buffer #(
        .LANES (ARR_WIDTH),
        .WIDTH (WIDTH)
    ) u_skew_north (
        .clk   (clk),
        .reset (reset),
        .load  (beat_fire),
        .din   (op_b),
        .dout  (sa_in_b)
    );

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Bench for systolic_tile_scheduler: a behavioural systolic array answers the scheduler,
// and results are compared against a plain matrix product of the driven beats.
module tb_systolic_tile_scheduler;
    import sys_ctrl_pkg::*;

    localparam int WIDTH   = 16;
    localparam int H       = 4;
    localparam int W       = 4;
    localparam int K_BITS  = 8;
    localparam int TIMEOUT = 255;
    localparam int CW      = H * W * WIDTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              cmd_valid = 1'b0;
    logic [K_BITS-1:0] cmd_k = '0;
    logic              op_valid = 1'b0;
    logic [H*WIDTH-1:0] op_a = '0;
    logic [W*WIDTH-1:0] op_b = '0;
    logic              sa_calc_done = 1'b0;
    logic [CW-1:0]     sa_out_c = '0;
    logic              res_ready = 1'b1;
    logic              cmd_ready, op_ready, sa_reset, sa_done, res_valid, err_timeout;
    logic [H*WIDTH-1:0] sa_in_a;
    logic [W*WIDTH-1:0] sa_in_b;
    logic [CW-1:0]     res_data;

    systolic_tile_scheduler #(
        .WIDTH(WIDTH), .ARR_HEIGHT(H), .ARR_WIDTH(W), .K_BITS(K_BITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .sa_reset(sa_reset), .sa_in_a(sa_in_a), .sa_in_b(sa_in_b), .sa_done(sa_done),
        .sa_calc_done(sa_calc_done), .sa_out_c(sa_out_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err_timeout(err_timeout)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_fail = 0;
    logic [CW-1:0] exp_q[$];
    bit            exp_err_q[$];

    task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic check_i(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- operand tables and reference product ----------------
    logic [WIDTH-1:0] a_beat [16][H];
    logic [WIDTH-1:0] b_beat [16][W];

    task automatic set_beats(input int mode);
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < H; i++) begin
                case (mode)
                    0:       a_beat[t][i] = WIDTH'(1);
                    1:       a_beat[t][i] = WIDTH'(t + i + 1);
                    2:       a_beat[t][i] = WIDTH'(i + 1);
                    3:       a_beat[t][i] = WIDTH'(5);
                    4:       a_beat[t][i] = WIDTH'(i + 1);
                    default: a_beat[t][i] = WIDTH'(3);
                endcase
            end
            for (int j = 0; j < W; j++) begin
                case (mode)
                    0:       b_beat[t][j] = WIDTH'(1);
                    1:       b_beat[t][j] = WIDTH'(t + 2 * j + 1);
                    2:       b_beat[t][j] = WIDTH'(j + 1);
                    3:       b_beat[t][j] = WIDTH'(5);
                    4:       b_beat[t][j] = WIDTH'(1);
                    default: b_beat[t][j] = WIDTH'(j);
                endcase
            end
        end
    endtask

    function automatic logic [CW-1:0] matmul(input int k);
        logic [CW-1:0]    r;
        logic [WIDTH-1:0] s;
        r = '0;
        for (int i = 0; i < H; i++) begin
            for (int j = 0; j < W; j++) begin
                s = '0;
                for (int t = 0; t < k; t++) s = s + a_beat[t][i] * b_beat[t][j];
                r[(i * W + j) * WIDTH +: WIDTH] = s;
            end
        end
        return r;
    endfunction

    // ---------------- behavioural systolic array ----------------
    // PE(i,j) sees west lane i delayed by j and north lane j delayed by i.
    logic [H*WIDTH-1:0] hist_a [16];
    logic [W*WIDTH-1:0] hist_b [16];
    logic [WIDTH-1:0]   acc [H][W];
    logic [H*WIDTH-1:0] av;
    logic [W*WIDTH-1:0] bv;
    bit pend = 1'b0;
    bit suppress = 1'b0;
    int done_at = 0;

    always @(negedge clk) begin
        if (!sa_reset) begin
            for (int t = 0; t < 16; t++) begin
                hist_a[t] = '0;
                hist_b[t] = '0;
            end
            for (int i = 0; i < H; i++)
                for (int j = 0; j < W; j++) acc[i][j] = '0;
            pend = 1'b0;
            sa_calc_done = 1'b0;
        end else begin
            hist_a[cyc & 15] = sa_in_a;
            hist_b[cyc & 15] = sa_in_b;
            for (int i = 0; i < H; i++) begin
                for (int j = 0; j < W; j++) begin
                    av = hist_a[(cyc - j) & 15];
                    bv = hist_b[(cyc - i) & 15];
                    acc[i][j] = acc[i][j] + av[i*WIDTH +: WIDTH] * bv[j*WIDTH +: WIDTH];
                end
            end
            sa_calc_done = 1'b0;
            if (pend && !suppress && (cyc == done_at + SA_DONE_LAT)) begin
                for (int i = 0; i < H; i++)
                    for (int j = 0; j < W; j++) sa_out_c[(i * W + j) * WIDTH +: WIDTH] = acc[i][j];
                sa_calc_done = 1'b1;
                pend = 1'b0;
            end
            if (sa_done) begin
                pend = 1'b1;
                done_at = cyc;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (reset && res_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL res_valid_unexpected: got 1 want 0");
            end else begin
                check("res_data", res_data, exp_q[0]);
                check_i("err_timeout", 32'(err_timeout), 32'(exp_err_q[0]));
                if (res_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_err_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_tile(input int k, input int gap_after, input int gap_len,
                            input bit expect_to, input int hold,
                            output int acc_cyc, output int res_cyc, output int hs_cyc);
        int fe, beat, gap, guard;
        bit seen_op;
        exp_q.push_back(expect_to ? '0 : matmul(k));
        exp_err_q.push_back(expect_to);
        cmd_valid = 1'b1;
        cmd_k = K_BITS'(k);
        guard = 0;
        while (!cmd_ready && guard < 1000) begin
            step();
            guard++;
        end
        check_i("cmd_accept", 32'(cmd_ready), 1);
        acc_cyc = cyc;
        step();
        cmd_valid = 1'b0;
        check_i("clear_sa_reset", 32'(sa_reset), 0);
        check_i("clear_err_cleared", 32'(err_timeout), 0);
        seen_op = op_ready;
        step();
        beat = 0;
        gap = 0;
        fe = acc_cyc + 1;
        guard = 0;
        if (k > 0) check_i("first_op_ready", 32'(op_ready), 1);
        while (beat < k && guard < 200) begin
            if (beat == gap_after && gap < gap_len) begin
                op_valid = 1'b0;
                gap++;
            end else begin
                op_valid = 1'b1;
                for (int i = 0; i < H; i++) op_a[i*WIDTH +: WIDTH] = a_beat[beat][i];
                for (int j = 0; j < W; j++) op_b[j*WIDTH +: WIDTH] = b_beat[beat][j];
            end
            if (op_valid && op_ready) begin
                fe = cyc;
                beat++;
            end
            step();
            guard++;
        end
        op_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        check_i("beats_accepted", beat, k);
        guard = 0;
        while (!sa_done && guard < 100) begin
            seen_op |= op_ready;
            step();
            guard++;
        end
        check_i("sa_done_cycle", cyc, fe + 4);
        guard = 0;
        while (!res_valid && guard < TIMEOUT + 100) begin
            seen_op |= op_ready;
            step();
            guard++;
        end
        res_cyc = cyc;
        check_i("res_valid_cycle", cyc, expect_to ? fe + 5 + TIMEOUT : fe + 4 + SA_DONE_LAT + 1);
        if (k == 0) check_i("k0_no_op_ready", 32'(seen_op), 0);
        res_ready = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            check_i("hold_res_valid", 32'(res_valid), 1);
            check_i("hold_cmd_ready", 32'(cmd_ready), 0);
            step();
        end
        res_ready = 1'b1;
        hs_cyc = cyc;
        step();
    endtask

    // ---------------- directed sequence ----------------
    logic [CW-1:0] saved_c;
    int acc_c, res_c, hs_c, hs_prev;
    int guard;

    initial begin
        repeat (3) step();
        check_i("rst_cmd_ready", 32'(cmd_ready), 1);
        check_i("rst_op_ready", 32'(op_ready), 0);
        check_i("rst_sa_reset", 32'(sa_reset), 0);
        check_i("rst_sa_done", 32'(sa_done), 0);
        check_i("rst_res_valid", 32'(res_valid), 0);
        check_i("rst_err", 32'(err_timeout), 0);
        check("rst_res_data", res_data, '0);
        check("rst_sa_in_a", CW'(sa_in_a), '0);
        check("rst_sa_in_b", CW'(sa_in_b), '0);
        reset = 1'b1;
        step();
        check_i("post_rst_sa_reset", 32'(sa_reset), 1);

        // K=4, all ones: every element 4, result 22 cycles after acceptance.
        set_beats(0);
        run_tile(4, -1, 0, 1'b0, 0, acc_c, res_c, hs_c);
        check_i("k4_res_latency", res_c - acc_c, 22);
        check_i("k4_elem00", 32'(res_data[15:0]), 4);
        check_i("k4_elem33", 32'(res_data[CW-1 -: WIDTH]), 4);

        // K=3 unstalled, then the same tile with a two-cycle gap after the first beat.
        set_beats(1);
        run_tile(3, -1, 0, 1'b0, 0, acc_c, res_c, hs_c);
        check_i("k3_elem00", 32'(res_data[15:0]), 14);
        check_i("k3_elem33", 32'(res_data[CW-1 -: WIDTH]), 122);
        saved_c = res_data;
        run_tile(3, 1, 2, 1'b0, 0, acc_c, res_c, hs_c);
        check("k3_stall_same", res_data, saved_c);

        // K=0: no beats, zero result.
        run_tile(0, -1, 0, 1'b0, 0, acc_c, res_c, hs_c);
        check("k0_zero", res_data, '0);

        // Result held 10 cycles with a command waiting, then back-to-back acceptance.
        set_beats(4);
        run_tile(1, -1, 0, 1'b0, 10, acc_c, res_c, hs_prev);
        check_i("hold_elem00", 32'(res_data[15:0]), 1);
        check_i("hold_elem30", 32'(res_data[12*WIDTH +: WIDTH]), 4);
        set_beats(5);
        run_tile(1, -1, 0, 1'b0, 0, acc_c, res_c, hs_c);
        check_i("b2b_accept_cycle", acc_c, hs_prev + 1);
        check_i("b2b_elem03", 32'(res_data[3*WIDTH +: WIDTH]), 9);

        // Completion never arrives: timeout with zero result; next command clears the flag.
        suppress = 1'b1;
        set_beats(2);
        run_tile(2, -1, 0, 1'b1, 0, acc_c, res_c, hs_c);
        check_i("to_latency", res_c - acc_c, 263);
        check_i("to_err_sticky", 32'(err_timeout), 1);
        check("to_zero", res_data, '0);
        suppress = 1'b0;
        set_beats(4);
        run_tile(1, -1, 0, 1'b0, 0, acc_c, res_c, hs_c);
        check_i("to_err_cleared", 32'(err_timeout), 0);

        // Reset in the middle of FEED, then a fresh K=2 tile.
        set_beats(3);
        cmd_valid = 1'b1;
        cmd_k = K_BITS'(4);
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            step();
            guard++;
        end
        step();
        cmd_valid = 1'b0;
        step();
        op_valid = 1'b1;
        op_a = {H{16'd5}};
        op_b = {W{16'd5}};
        step();
        step();
        op_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        reset = 1'b0;
        step();
        check_i("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        check_i("mid_rst_op_ready", 32'(op_ready), 0);
        check_i("mid_rst_sa_reset", 32'(sa_reset), 0);
        check_i("mid_rst_sa_done", 32'(sa_done), 0);
        check_i("mid_rst_res_valid", 32'(res_valid), 0);
        check("mid_rst_res_data", res_data, '0);
        check("mid_rst_sa_in_a", CW'(sa_in_a), '0);
        check("mid_rst_sa_in_b", CW'(sa_in_b), '0);
        step();
        reset = 1'b1;
        step();
        set_beats(2);
        run_tile(2, -1, 0, 1'b0, 0, acc_c, res_c, hs_c);
        check_i("fresh_elem00", 32'(res_data[15:0]), 2);
        check_i("fresh_elem33", 32'(res_data[CW-1 -: WIDTH]), 32);

        repeat (3) step();
        check_i("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/systolic_tile_scheduler.md
# systolic_tile_scheduler

Sequencing controller for one `systolic_array_with_buffer` instance. It accepts a tile command carrying the reduction length K, clears the array, and streams K operand beats into the array's west and north edges with per-lane diagonal skew. It then flushes the skew lines, issues the done pulse and waits for `calc_done_flag`. Finally it captures `out_c` and holds it on a valid/ready result port. It sits between the operand fetch logic and the array wrapper.

## Interface
Parameters:
- `WIDTH`, 16, element width in bits
- `ARR_HEIGHT`, 4, array rows (west lanes)
- `ARR_WIDTH`, 4, array columns (north lanes)
- `K_BITS`, 8, width of the K field
- `TIMEOUT`, 255, maximum cycles spent in WAIT before the error flag is raised

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `cmd_valid`  in  1  tile command present
- `cmd_ready`  out  1  command accepted when both are high
- `cmd_k`  in  K_BITS  number of operand beats in the tile
- `op_valid`  in  1  operand beat present
- `op_ready`  out  1  operand beat accepted when both are high
- `op_a`  in  ARR_HEIGHT*WIDTH  unskewed west column; lane i is at bits [i*WIDTH +: WIDTH]
- `op_b`  in  ARR_WIDTH*WIDTH  unskewed north row; lane j is at bits [j*WIDTH +: WIDTH]
- `sa_reset`  out  1  drives the array reset; active-low
- `sa_in_a`  out  ARR_HEIGHT*WIDTH  skewed west data
- `sa_in_b`  out  ARR_WIDTH*WIDTH  skewed north data
- `sa_done`  out  1  drives the array `in_done_flag`
- `sa_calc_done`  in  1  from the array `calc_done_flag`
- `sa_out_c`  in  ARR_HEIGHT*ARR_WIDTH*WIDTH  from the array `out_c`
- `res_valid`  out  1  result held
- `res_ready`  in  1  result consumed when both are high
- `res_data`  out  ARR_HEIGHT*ARR_WIDTH*WIDTH  captured result tile
- `err_timeout`  out  1  sticky flag; cleared when the next command is accepted

## Operation
- State machine: IDLE → CLEAR → FEED → FLUSH → DONE → WAIT → RESULT → IDLE.
- **IDLE**
  - `cmd_ready`=1. On handshake, latch `cmd_k`, clear `err_timeout` and go to CLEAR.
  - `cmd_ready`=0 in every other state.
- **CLEAR**
  - Exactly one cycle with `sa_reset`=0. This zeroes the array accumulators and the wrapper's done FIFOs.
  - Next state is FEED, or FLUSH if K=0.
- **FEED**
  - `op_ready`=1. Each accepted beat loads `op_a`/`op_b` into the skew stage and increments the beat count.
  - A cycle without `op_valid` injects zeros on all lanes. The products are zero, so the result is unchanged.
  - After the K-th beat, go to FLUSH.
- **Skew**
  - West lane i is delayed by i cycles; north lane j is delayed by j cycles.
  - The delay lines shift every cycle in every state and fill with zeros when no beat is accepted.
  - Lane 0 passes through a single output register, so all lanes have 1 + index cycles of latency.
- **FLUSH**
  - Feeds zeros for max(ARR_HEIGHT, ARR_WIDTH)−1 cycles; a counter enforces this even when the value is 0.
  - Then go to DONE.
- **DONE**
  - One cycle with `sa_done`=1. Next state is WAIT.
- **WAIT**
  - On `sa_calc_done`=1, register `sa_out_c` into `res_data` and go to RESULT.
  - If the WAIT cycle counter reaches TIMEOUT: set `err_timeout`, load zeros into `res_data`, go to RESULT.
- **RESULT**
  - `res_valid`=1 and `res_data` stable until `res_ready`; then go to IDLE.
- `sa_calc_done` is ignored outside WAIT.
- K counter width is K_BITS; no wrap is possible because the count stops at K.

## Timing
- Reset values:
  - state IDLE
  - `cmd_ready`=1
  - `op_ready`=0
  - `sa_reset`=0 while `reset` is low, then 1
  - `sa_done`=0
  - `res_valid`=0
  - `res_data`=0
  - `sa_in_a`/`sa_in_b`=0
  - `err_timeout`=0
  - skew registers cleared
- A reset asserted mid-tile abandons the tile. The array is reset in the same cycle through `sa_reset`.
- Command accepted at cycle 0:
  - CLEAR at cycle 1
  - first `op_ready` at cycle 2
  - last beat at 2+K−1 when there are no stalls
- `sa_done` pulses max(H,W)−1+1 cycles after the FEED exit.
- The array returns `calc_done` H+W+4 cycles after `sa_done`.
- `res_valid` rises one cycle after `sa_calc_done`.
- A back-to-back command is accepted the cycle after the result handshake, since IDLE asserts `cmd_ready` combinationally from the state.

## Structure
- Shared package `sys_ctrl_pkg`:
  - state enum (3-bit encoding)
  - localparam `SKEW_DEPTH` = max(ARR_HEIGHT, ARR_WIDTH)
  - localparam `SA_DONE_LAT` = ARR_HEIGHT+ARR_WIDTH+4
- Sub-module `skew_buffer`, parameterised by lane count and WIDTH: a triangular delay array. It is instantiated twice, once for west and once for north.

## Test plan
- K=4, all-ones operands, `op_valid` always high, `res_ready` high → every `res_data` element is 4.0; `res_valid` rises exactly at the computed cycle.
- K=3, with `op_valid` low for 2 cycles between beats 1 and 2 → result identical to the unstalled run.
- K=0 → result is all zeros; no `op_ready` pulse is ever seen.
- `res_ready` held low for 10 cycles with `cmd_valid` high → `res_data` is stable, `cmd_ready` stays 0, and the second command is accepted only after the handshake.
- `sa_calc_done` forced low → `err_timeout`=1 after TIMEOUT cycles, result is zeros; the next command clears the flag.
- `reset` driven low in the middle of FEED → all outputs return to their reset values; a fresh K=2 tile then produces the correct result with no leftover accumulation.
